// File: rtl/conv_frame_ctrl_if.sv
// Pixel stream bundle for conv_frame_ctrl: upstream valid/ready input and tagged result output.
// The slave modport is the controller; the master modport is its environment.
interface conv_frame_ctrl_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ROW_SIZE  = 540,
  parameter int unsigned COL_SIZE  = 480
);
  localparam int unsigned ROW_W = $clog2(COL_SIZE);
  localparam int unsigned COL_W = $clog2(ROW_SIZE);

  logic                 in_valid;
  logic [WORD_SIZE-1:0] in_pixel;
  logic                 in_ready;
  logic                 out_valid;
  logic [WORD_SIZE-1:0] out_pixel;
  logic [ROW_W-1:0]     out_row;
  logic [COL_W-1:0]     out_col;

  modport master (
    output in_valid, in_pixel,
    input  in_ready, out_valid, out_pixel, out_row, out_col
  );

  modport slave (
    input  in_valid, in_pixel,
    output in_ready, out_valid, out_pixel, out_row, out_col
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the streaming 3x3 Laplacian datapath: clears it, feeds pixels,
// drains it with zeros, re-times its valid and tags each result with row/column.
module conv_frame_ctrl #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ROW_SIZE  = 540,
  parameter int unsigned COL_SIZE  = 480,
  parameter int unsigned VALID_LAT = 3,
  parameter int unsigned FLUSH_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  conv_frame_ctrl_if.slave     bus,
  output logic                 conv_rst,
  output logic [WORD_SIZE-1:0] conv_pixel,
  input  logic [WORD_SIZE-1:0] conv_out_pixel,
  input  logic [1:0]           conv_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_underrun,
  output logic                 err_timeout
);

  localparam int unsigned IN_TOTAL  = ROW_SIZE * COL_SIZE;
  localparam int unsigned OUT_COLS  = ROW_SIZE - 2;
  localparam int unsigned OUT_TOTAL = OUT_COLS * (COL_SIZE - 2);
  localparam int unsigned IN_CNT_W  = $clog2(IN_TOTAL + 1);
  localparam int unsigned OUT_CNT_W = $clog2(OUT_TOTAL + 1);
  localparam int unsigned FL_W      = $clog2(FLUSH_MAX + 1);
  localparam int unsigned ROW_W     = $clog2(COL_SIZE);
  localparam int unsigned COL_W     = $clog2(ROW_SIZE);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, FLUSH} state_t;

  state_t               state_q, state_d;
  logic [IN_CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [FL_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [VALID_LAT-1:0] vsr_q, vsr_d;
  logic                 done_q, done_d;
  logic                 err_u_q, err_u_d;
  logic                 err_t_q, err_t_d;
  logic                 out_valid_c;
  logic                 last_out_c;

  // Only bit 0 of the datapath valid carries meaning.
  logic unused_conv_valid;
  assign unused_conv_valid = conv_valid[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      vsr_q       <= '0;
      done_q      <= 1'b0;
      err_u_q     <= 1'b0;
      err_t_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      vsr_q       <= vsr_d;
      done_q      <= done_d;
      err_u_q     <= err_u_d;
      err_t_q     <= err_t_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    vsr_d       = (vsr_q << 1) | VALID_LAT'(conv_valid[0]);
    done_d      = 1'b0;
    err_u_d     = err_u_q;
    err_t_d     = err_t_q;

    out_valid_c = vsr_q[VALID_LAT-1] && ((state_q == STREAM) || (state_q == FLUSH)) &&
                  (out_cnt_q < OUT_CNT_W'(OUT_TOTAL));
    last_out_c  = out_valid_c && (out_cnt_q == OUT_CNT_W'(OUT_TOTAL - 1));

    // Raster-order coordinate tracking of accepted results.
    if (out_valid_c) begin
      out_cnt_d = out_cnt_q + 1'b1;
      if (col_q == COL_W'(OUT_COLS - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          err_u_d = 1'b0;
          err_t_d = 1'b0;
        end
      end
      CLEAR: begin
        state_d     = STREAM;
        vsr_d       = '0;
        in_cnt_d    = '0;
        out_cnt_d   = '0;
        flush_cnt_d = '0;
        row_d       = '0;
        col_d       = '0;
      end
      STREAM: begin
        // The datapath cannot stall, so a missing pixel kills the frame.
        if (!bus.in_valid) begin
          err_u_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_CNT_W'(IN_TOTAL - 1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if ((out_cnt_q == OUT_CNT_W'(OUT_TOTAL)) || last_out_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (flush_cnt_d == FL_W'(FLUSH_MAX)) begin
          err_t_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign conv_rst      = rst || (state_q == CLEAR);
  assign conv_pixel    = (state_q == STREAM) ? bus.in_pixel : '0;
  assign bus.in_ready  = (state_q == STREAM);
  assign bus.out_valid = out_valid_c;
  assign bus.out_pixel = out_valid_c ? conv_out_pixel : '0;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = done_q;
  assign err_underrun  = err_u_q;
  assign err_timeout   = err_t_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl on a 5x4 frame with an ideal Laplacian datapath model
// and a raster-order scoreboard of expected results.
module tb_conv_frame_ctrl;

  localparam int W         = 8;
  localparam int RS        = 5;
  localparam int CS        = 4;
  localparam int VL        = 3;
  localparam int FM        = 16;
  localparam int IN_TOTAL  = RS * CS;
  localparam int OUT_COLS  = RS - 2;
  localparam int OUT_TOTAL = OUT_COLS * (CS - 2);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         conv_rst;
  logic [W-1:0] conv_pixel;
  logic [W-1:0] conv_out_pixel;
  logic [1:0]   conv_valid;
  logic         busy, frame_done, err_underrun, err_timeout;

  conv_frame_ctrl_if #(.WORD_SIZE(W), .ROW_SIZE(RS), .COL_SIZE(CS)) bus ();

  conv_frame_ctrl #(
    .WORD_SIZE(W), .ROW_SIZE(RS), .COL_SIZE(CS), .VALID_LAT(VL), .FLUSH_MAX(FM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
    .conv_rst(conv_rst), .conv_pixel(conv_pixel), .conv_out_pixel(conv_out_pixel),
    .conv_valid(conv_valid), .busy(busy), .frame_done(frame_done),
    .err_underrun(err_underrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] clamp_lap(input int center, input int nsum);
    int v;
    v = 8 * center - nsum;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Ideal datapath: pixel n enters while it is on conv_pixel, valid follows one cycle
  // later for every full window, result pixel VL cycles after that.
  logic [W-1:0] dp_mem [IN_TOTAL];
  logic [W-1:0] dp_val [VL+1];
  logic         dp_v;
  int           dp_n;
  bit           withhold_last;

  function automatic bit win_at(input int n);
    return (n < IN_TOTAL) && ((n / RS) >= 2) && ((n % RS) >= 2);
  endfunction

  function automatic logic [7:0] dp_lap(input int n, input logic [7:0] cur);
    int r, c, nsum, idx;
    r = n / RS;
    c = n % RS;
    nsum = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        idx = (r - 2 + dr) * RS + (c - 2 + dc);
        if (dr == 2 && dc == 2) nsum += int'(cur);
        else if (!(dr == 1 && dc == 1)) nsum += int'(dp_mem[idx]);
      end
    end
    return clamp_lap(int'(dp_mem[(r - 1) * RS + c - 1]), nsum);
  endfunction

  always @(posedge clk) begin
    if (conv_rst) begin
      dp_n <= 0;
      dp_v <= 1'b0;
      for (int i = 0; i <= VL; i++) dp_val[i] <= '0;
    end else begin
      if (dp_n < IN_TOTAL) dp_mem[dp_n] <= conv_pixel;
      if (dp_n <= IN_TOTAL) dp_n <= dp_n + 1;
      dp_v      <= win_at(dp_n) && !(withhold_last && dp_n == IN_TOTAL - 1);
      dp_val[0] <= win_at(dp_n) ? dp_lap(dp_n, conv_pixel) : 8'd0;
      for (int i = 1; i <= VL; i++) dp_val[i] <= dp_val[i-1];
    end
  end

  assign conv_valid     = {1'b1, dp_v};
  assign conv_out_pixel = dp_val[VL];

  // Reference: every 3x3 window of the input frame, in raster order.
  typedef struct { int row; int col; int pix; } exp_t;
  exp_t         expq[$];
  logic [W-1:0] frame [IN_TOTAL];

  task automatic build_expected();
    exp_t e;
    int   nsum;
    expq.delete();
    for (int r = 0; r < CS - 2; r++) begin
      for (int c = 0; c < RS - 2; c++) begin
        nsum = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            if (!(dr == 1 && dc == 1)) nsum += int'(frame[(r + dr) * RS + c + dc]);
        e.row = r;
        e.col = c;
        e.pix = int'(clamp_lap(int'(frame[(r + 1) * RS + c + 1]), nsum));
        expq.push_back(e);
      end
    end
  endtask

  bit mon_en = 1'b0;
  int n_out, n_ready, n_crst, n_done, n_flush;
  int obs_row[$], obs_col[$], obs_pix[$];

  initial begin : monitor
    bit   prev_busy;
    bit   prev_start;
    exp_t e;
    prev_busy  = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) check("conv_rst_during_rst", conv_rst, 1);
        else if (conv_rst) check("conv_rst_after_idle_start", prev_start && !prev_busy, 1);
        check("conv_pixel_gate", conv_pixel, bus.in_ready ? bus.in_pixel : 8'd0);
        check("in_ready_when_idle", bus.in_ready && !busy, 0);
        check("out_valid_when_idle", bus.out_valid && !busy, 0);
        if (bus.out_valid) begin
          n_out++;
          obs_row.push_back(int'(bus.out_row));
          obs_col.push_back(int'(bus.out_col));
          obs_pix.push_back(int'(bus.out_pixel));
          if (expq.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            e = expq.pop_front();
            check("out_row", bus.out_row, e.row);
            check("out_col", bus.out_col, e.col);
            check("out_pixel", bus.out_pixel, e.pix);
          end
        end
        if (frame_done) begin
          n_done++;
          check("busy_low_at_done", busy, 0);
          check("busy_high_before_done", prev_busy, 1);
        end
        if (bus.in_ready) n_ready++;
        if (conv_rst) n_crst++;
        if (busy && !bus.in_ready && !conv_rst) n_flush++;
      end
      prev_busy  = busy;
      prev_start = start;
    end
  end

  // One frame: start pulse, pixels on every ready cycle, optional abort/extra start/reset.
  task automatic run_frame(input int abort_at, input int dup_at, input int rst_at,
                           input bit hold, input bit pattern, input int tail);
    int k, guard, exp_k;
    bit stop, acc, seen;
    for (int i = 0; i < IN_TOTAL; i++) frame[i] = pattern ? 8'd10 : 8'($urandom_range(1, 255));
    if (pattern) begin
      frame[6]  = 8'd50;
      frame[13] = 8'd30;
    end
    build_expected();
    withhold_last = hold;
    n_out = 0; n_ready = 0; n_crst = 0; n_done = 0; n_flush = 0;
    obs_row.delete(); obs_col.delete(); obs_pix.delete();
    exp_k = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : IN_TOTAL);

    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; guard = 0; stop = 1'b0;
    while (!stop && k < IN_TOTAL && guard < 4 * IN_TOTAL) begin
      bus.in_pixel = frame[k];
      bus.in_valid = (k != abort_at);
      start        = (k == dup_at);
      rst          = (k == rst_at);
      @(negedge clk);
      stop = bus.in_ready && (k == abort_at || k == rst_at);
      acc  = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;
      if (acc && !stop) k++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_pixel = 8'hA5;
    check("pixels_accepted", k, exp_k);

    if (rst_at < 0) begin
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        seen = frame_done;
      end
      #1;
      check("frame_done_seen", seen, 1);
    end
    repeat (tail) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    withhold_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_conv_rst", conv_rst, 1);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pixel", bus.out_pixel, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_out_col", bus.out_col, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_underrun", err_underrun, 0);
    check("rst_err_timeout", err_timeout, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_conv_rst", conv_rst, 0);

    // Normal frame with a hand-computed pattern.
    run_frame(-1, -1, -1, 1'b0, 1'b1, 3);
    check("t1_outputs", n_out, 6);
    check("t1_ready_cycles", n_ready, 20);
    check("t1_conv_rst_cycles", n_crst, 1);
    check("t1_done_pulses", n_done, 1);
    check("t1_flush_cycles", n_flush, 4);
    check("t1_err_underrun", err_underrun, 0);
    check("t1_err_timeout", err_timeout, 0);
    check("t1_busy", busy, 0);
    check("t1_pending", expq.size(), 0);
    if (n_out == 6) begin
      int lit_row[6] = '{0, 0, 0, 1, 1, 1};
      int lit_col[6] = '{0, 1, 2, 0, 1, 2};
      int lit_pix[6] = '{255, 0, 0, 0, 0, 160};
      for (int i = 0; i < 6; i++) begin
        check("t1_lit_row", obs_row[i], lit_row[i]);
        check("t1_lit_col", obs_col[i], lit_col[i]);
        check("t1_lit_pix", obs_pix[i], lit_pix[i]);
      end
    end

    // Underrun at pixel 9, then a clean frame clears the sticky flag.
    run_frame(9, -1, -1, 1'b0, 1'b0, 3);
    check("t2_err_underrun", err_underrun, 1);
    check("t2_err_timeout", err_timeout, 0);
    check("t2_done_pulses", n_done, 1);
    check("t2_outputs", n_out, 0);
    check("t2_ready_cycles", n_ready, 10);
    check("t2_in_ready", bus.in_ready, 0);
    check("t2_busy", busy, 0);
    run_frame(-1, -1, -1, 1'b0, 1'b0, 3);
    check("t2b_err_underrun", err_underrun, 0);
    check("t2b_outputs", n_out, 6);
    check("t2b_done_pulses", n_done, 1);

    // Final window never reported: drain times out.
    run_frame(-1, -1, -1, 1'b1, 1'b0, 3);
    check("t3_outputs", n_out, 5);
    check("t3_err_timeout", err_timeout, 1);
    check("t3_err_underrun", err_underrun, 0);
    check("t3_flush_cycles", n_flush, 16);
    check("t3_done_pulses", n_done, 1);
    check("t3_pending", expq.size(), 1);

    // Start pulse during streaming is ignored.
    run_frame(-1, 5, -1, 1'b0, 1'b0, 3);
    check("t4_done_pulses", n_done, 1);
    check("t4_outputs", n_out, 6);
    check("t4_conv_rst_cycles", n_crst, 1);
    check("t4_ready_cycles", n_ready, 20);
    check("t4_err_timeout", err_timeout, 0);

    // Reset mid-frame, then a fresh frame.
    run_frame(-1, -1, 12, 1'b0, 1'b0, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", bus.in_ready, 0);
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_frame_done", frame_done, 0);
    check("t5_conv_rst", conv_rst, 0);
    check("t5_out_row", bus.out_row, 0);
    check("t5_out_col", bus.out_col, 0);
    check("t5_err_underrun", err_underrun, 0);
    check("t5_err_timeout", err_timeout, 0);
    repeat (5) @(negedge clk);
    #1;
    check("t5_no_done", n_done, 0);
    check("t5_no_outputs", n_out, 0);
    run_frame(-1, -1, -1, 1'b0, 1'b0, 3);
    check("t5b_outputs", n_out, 6);
    check("t5b_done_pulses", n_done, 1);

    // Back-to-back frames, second start the cycle after frame_done.
    run_frame(-1, -1, -1, 1'b0, 1'b0, 0);
    check("t6a_outputs", n_out, 6);
    check("t6a_done_pulses", n_done, 1);
    if (n_out == 6) begin
      check("t6a_last_row", obs_row[5], 1);
      check("t6a_last_col", obs_col[5], 2);
    end
    run_frame(-1, -1, -1, 1'b0, 1'b0, 3);
    check("t6b_outputs", n_out, 6);
    check("t6b_done_pulses", n_done, 1);
    check("t6b_flush_cycles", n_flush, 4);
    check("t6b_conv_rst_cycles", n_crst, 1);
    if (n_out > 0) begin
      check("t6b_first_row", obs_row[0], 0);
      check("t6b_first_col", obs_col[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
Frame-level sequencer for the streaming 3x3 Laplacian convolution datapath.
- Accepts a start command and a valid/ready pixel stream from upstream, and feeds the convolution one pixel per clock.
- Issues the datapath reset between frames and drains the pipeline with zero pixels after the last input pixel.
- Re-times the datapath's valid onto its registered output pixel and tags each result with output row/column.
- Reports frame completion, underrun and drain timeout.

Parameters:
WORD_SIZE, 8, pixel width
ROW_SIZE, 540, pixels per input row (must match the datapath)
COL_SIZE, 480, rows per input frame
VALID_LAT, 3, cycles from conv_valid[0] high to the matching conv_out_pixel
FLUSH_MAX, 16, maximum drain cycles before timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle frame start request
in_valid  in  1  upstream pixel valid
in_pixel  in  WORD_SIZE  upstream pixel
in_ready  out  1  pixel accepted this cycle when in_valid & in_ready
conv_rst  out  1  reset to the convolution datapath
conv_pixel  out  WORD_SIZE  pixel driven into the datapath
conv_out_pixel  in  WORD_SIZE  datapath clamped output
conv_valid  in  2  datapath valid; only bit 0 is used
out_valid  out  1  result pixel valid
out_pixel  out  WORD_SIZE  result pixel
out_row  out  $clog2(COL_SIZE)  output row index, 0-based
out_col  out  $clog2(ROW_SIZE)  output column index, 0-based
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at end of frame (normal or error)
err_underrun  out  1  sticky; cleared by start or rst
err_timeout  out  1  sticky; cleared by start or rst

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values:
  - All outputs 0, except conv_rst = 1 (conv_rst = rst OR state==CLEAR, combinational).
  - State IDLE; all counters and the valid delay line cleared.
- Derived constants: IN_TOTAL = ROW_SIZE*COL_SIZE; OUT_COLS = ROW_SIZE-2; OUT_TOTAL = OUT_COLS*(COL_SIZE-2).
- conv_pixel: equals in_pixel in STREAM, 0 otherwise. Combinational.
- in_ready: 1 only in STREAM.
- States:
  - IDLE: start=1 -> CLEAR. Sticky errors are cleared on that edge.
  - CLEAR: exactly one cycle. conv_rst=1; valid delay line and in/out counters zeroed. -> STREAM.
  - STREAM: each cycle with in_valid=1, one pixel is accepted and in_cnt increments. After pixel IN_TOTAL is accepted -> FLUSH.
    - If in_valid=0 in STREAM, the datapath has no stall, so the frame is aborted.
    - Abort: set err_underrun, pulse frame_done, -> IDLE. The next frame's CLEAR resets the datapath.
  - FLUSH: conv_pixel=0 and flush_cnt increments each cycle.
    - When out_cnt reaches OUT_TOTAL: pulse frame_done, -> IDLE.
    - Else when flush_cnt reaches FLUSH_MAX: set err_timeout, pulse frame_done, -> IDLE.
- start while busy=1 is ignored.
- Output alignment:
  - conv_valid[0] enters a VALID_LAT-deep shift register.
  - out_valid = last stage AND (state==STREAM or FLUSH) AND out_cnt < OUT_TOTAL.
  - out_pixel = conv_out_pixel in the same cycle as out_valid. No backpressure on the output side.
- Coordinates:
  - out_col/out_row give the coordinates of the current out_valid pixel.
  - After each out_valid, out_col increments. At OUT_COLS-1 it wraps to 0 and out_row increments.
  - out_cnt increments per out_valid.
  - Window alignment within rows is the datapath's responsibility; this block only counts.
- Counter widths: in_cnt $clog2(IN_TOTAL+1) bits; out_cnt $clog2(OUT_TOTAL+1) bits; flush_cnt $clog2(FLUSH_MAX+1) bits.
- Simultaneous events:
  - The OUT_TOTAL-th out_valid and flush_cnt==FLUSH_MAX in the same cycle: treated as success; err_timeout stays 0.
  - out_valid in the same cycle as the last input pixel is counted normally.
- rst mid-frame: immediate return to IDLE. No frame_done pulse; conv_rst held high while rst=1.

Test Plan:
- ROW_SIZE=5, COL_SIZE=4, ideal datapath model. rst, then start, then 20 back-to-back pixels -> conv_rst high exactly 1 cycle after start; in_ready high for 20 cycles; 6 out_valid with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); frame_done 1 cycle; busy falls the same cycle; no errors.
- Same setup, in_valid deasserted at pixel 9 -> err_underrun=1, frame_done pulse, IDLE, in_ready=0; next start clears err_underrun and the frame completes normally.
- Datapath model withholds the final conv_valid, FLUSH_MAX=16 -> 5 outputs, then err_timeout=1 after 16 flush cycles, frame_done pulse.
- start pulsed during STREAM -> ignored; in_cnt and out coordinates unaffected; exactly one frame_done.
- rst asserted at pixel 12 -> next cycle: busy=0, all outputs at reset values, conv_rst=1 during rst, no frame_done; fresh start yields a correct 6-output frame.
- Two frames back to back, start issued the cycle after frame_done -> second frame coordinates restart at (0,0); conv_pixel=0 during both FLUSH phases.
